// File: rtl/vec_cpu_pkg.sv
// Shared definitions for the vector CPU pipeline: control flag layout,
// default vector geometry and the stage payload record.
package vec_cpu_pkg;

    localparam int CTRL_W         = 5;
    localparam int CTRL_REGWRITE  = 4;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_JUMP      = 2;
    localparam int CTRL_BRANCH    = 1;
    localparam int CTRL_RESULTSRC = 0;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_W   = 4;
    localparam int DEF_ALUC_W = 4;

    // Payload of one ID->EXE slot at the default geometry.
    typedef struct packed {
        logic [DEF_LANES*DEF_DATA_W-1:0] op1;
        logic [DEF_LANES*DEF_DATA_W-1:0] op2;
        logic [DEF_RD_W-1:0]             rd;
        logic [DEF_ALUC_W-1:0]           aluctl;
        logic [CTRL_W-1:0]               ctrl;
    } stage_payload_t;

    // Flat payload width for an arbitrary geometry.
    function automatic int payload_w(input int lanes, input int data_w,
                                     input int rd_w, input int aluc_w);
        return 2 * lanes * data_w + rd_w + aluc_w + CTRL_W;
    endfunction

endpackage

// File: rtl/vec_stage_entry.sv
// One pipeline payload slot: clears on reset or clear, loads on load.
module vec_stage_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    // Clear wins over load so a flushed slot never captures new data.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/id_exe_vec_stage.sv
// ID->EXE vector pipeline register with valid/ready handshake, flush,
// bubble-gated control flags and a saturating stall counter.
// Optional macro SKID_BUFFER_EN adds a second entry so in_ready depends
// on registers only (no out_ready -> in_ready path).
module id_exe_vec_stage
    import vec_cpu_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int ALUC_W = DEF_ALUC_W,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_op1,
    input  logic [LANES*DATA_W-1:0]   in_op2,
    input  logic [RD_W-1:0]           in_rd,
    input  logic [ALUC_W-1:0]         in_aluctl,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_op1,
    output logic [LANES*DATA_W-1:0]   out_op2,
    output logic [RD_W-1:0]           out_rd,
    output logic [ALUC_W-1:0]         out_aluctl,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int PW = payload_w(LANES, DATA_W, RD_W, ALUC_W);

    logic              main_valid_reg;
    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     main_d;
    logic [PW-1:0]     main_q;
    logic              main_load;
    logic              accept;
    logic              consume;
    logic [CTRL_W-1:0] held_ctrl;
    logic [CNT_W-1:0]  stall_cnt_reg;

    assign in_payload = {in_op1, in_op2, in_rd, in_aluctl, in_ctrl};
    assign accept     = in_valid && in_ready;
    assign consume    = main_valid_reg && out_ready;

`ifdef SKID_BUFFER_EN
    logic          skid_valid_reg;
    logic [PW-1:0] skid_q;
    logic          skid_load;

    assign in_ready  = !reset && !flush && !skid_valid_reg;
    // Skid is only ever occupied behind a full main slot, so when it is
    // valid in_ready is low and the refill of main comes purely from skid.
    assign main_load = (consume && skid_valid_reg) ||
                       (accept && (!main_valid_reg || consume));
    assign main_d    = skid_valid_reg ? skid_q : in_payload;
    assign skid_load = accept && main_valid_reg && !consume;

    // Occupancy of both slots; flush empties everything.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_valid_reg <= consume ? (skid_valid_reg || accept)
                                      : (main_valid_reg || accept);
            skid_valid_reg <= skid_valid_reg ? !consume : skid_load;
        end
    end

    vec_stage_entry #(.W(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (flush || (consume && skid_valid_reg)),
        .d     (in_payload),
        .q     (skid_q)
    );
`else
    assign in_ready  = !reset && !flush && (!main_valid_reg || out_ready);
    assign main_load = accept;
    assign main_d    = in_payload;

    // Single-slot occupancy: accept refills, consume alone empties.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid_reg <= 1'b0;
        end else if (accept) begin
            main_valid_reg <= 1'b1;
        end else if (consume) begin
            main_valid_reg <= 1'b0;
        end
    end
`endif

    vec_stage_entry #(.W(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (flush),
        .d     (main_d),
        .q     (main_q)
    );

    assign {out_op1, out_op2, out_rd, out_aluctl, held_ctrl} = main_q;
    assign out_valid = main_valid_reg;

    // An empty slot must never present write enables downstream.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign out_ctrl[gi] = held_ctrl[gi] & main_valid_reg;
        end
    endgenerate

    // Count back-pressured cycles, saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (main_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_id_exe_vec_stage.sv
// Bench for id_exe_vec_stage: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_id_exe_vec_stage;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int RD_W   = 4;
    localparam int ALUC_W = 4;
    localparam int CNT_W  = 4;
    localparam int OPW    = LANES * DATA_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SKID_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [OPW-1:0]    in_op1, in_op2, out_op1, out_op2;
    logic [RD_W-1:0]   in_rd, out_rd;
    logic [ALUC_W-1:0] in_aluctl, out_aluctl;
    logic [4:0]        in_ctrl, out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_exe_vec_stage #(
        .LANES(LANES), .DATA_W(DATA_W), .RD_W(RD_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
        .in_aluctl(in_aluctl), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_aluctl(out_aluctl), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: FIFO of in-flight instructions with capacity CAP.
    typedef struct packed {
        logic [OPW-1:0]    op1;
        logic [OPW-1:0]    op2;
        logic [RD_W-1:0]   rd;
        logic [ALUC_W-1:0] aluctl;
        logic [4:0]        ctrl;
    } ent_t;

    ent_t mq[$];
    int   mcnt = 0;

    function automatic logic m_ready();
        if (reset || flush) return 1'b0;
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin : model
        logic acc, cons;
        ent_t e;
        acc  = in_valid && m_ready();
        cons = (mq.size() > 0) && out_ready;
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (cons) void'(mq.pop_front());
                if (acc) begin
                    e = '{op1: in_op1, op2: in_op2, rd: in_rd, aluctl: in_aluctl, ctrl: in_ctrl};
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("m_in_ready", in_ready, m_ready());
        chk("m_out_valid", out_valid, mq.size() > 0);
        chk("m_stall_cnt", stall_cnt, mcnt);
        if (mq.size() > 0) begin
            chk("m_op1", out_op1, mq[0].op1);
            chk("m_op2", out_op2, mq[0].op2);
            chk("m_rd", out_rd, mq[0].rd);
            chk("m_aluctl", out_aluctl, mq[0].aluctl);
            chk("m_ctrl", out_ctrl, mq[0].ctrl);
        end else begin
            chk("m_ctrl_bubble", out_ctrl, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OPW-1:0] o1, input logic [OPW-1:0] o2,
                         input logic [3:0] rd, input logic [3:0] al, input logic [4:0] c);
        in_valid  = v;
        in_op1    = o1;
        in_op2    = o2;
        in_rd     = rd;
        in_aluctl = al;
        in_ctrl   = c;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, {4{16'h5555}}, {4{16'hAAAA}}, 4'hF, 4'hF, 5'h1F);

        // Reset held 2 cycles with in_valid high.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_ctrl", out_ctrl, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready, 1);

        // Streaming: 8 back-to-back instructions.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, {4{16'(16'h1000 + k)}},
                  {16'(k + 3), 16'(k + 2), 16'(k + 1), 16'(k)},
                  4'(k), 4'(15 - k), 5'(k));
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_lane0", out_op1[15:0], 16'h1000 + k);
            chk("stream_op2_lane3", out_op2[63:48], k + 3);
            chk("stream_rd", out_rd, k);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", out_valid, 0);
        chk("stream_stall_cnt", stall_cnt, 0);

        // Stall: hold 0xBEEF for 5 cycles.
        out_ready = 1'b0;
        drive(1'b1, {4{16'hBEEF}}, {4{16'h1234}}, 4'h7, 4'h3, 5'b10001);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_op1", out_op1, 64'hBEEF_BEEF_BEEF_BEEF);
            chk("stall_ctrl", out_ctrl, 5'b10001);
`ifndef SKID_BUFFER_EN
            chk("stall_in_ready", in_ready, 0);
`endif
        end
        chk("stall_cnt5", stall_cnt, 5);
        out_ready = 1'b1;
        tick();
        chk("stall_consumed_once", out_valid, 0);
        chk("stall_cnt_kept", stall_cnt, 5);

        // Flush: held entry and incoming instruction are both discarded.
        drive(1'b1, {4{16'hCAFE}}, {4{16'h0001}}, 4'h2, 4'h1, 5'b11000);
        tick();
        chk("flush_pre_ctrl", out_ctrl, 5'b11000);
        flush = 1'b1;
        drive(1'b1, {4{16'hDEAD}}, {4{16'h0002}}, 4'h3, 4'h2, 5'b10100);
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_stall_cnt", stall_cnt, 5);
        tick();
        chk("flush_incoming_dropped", out_valid, 0);

        // Saturation: 20 stall cycles with a 4-bit counter.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, {4{16'hA5A5}}, {4{16'h5A5A}}, 4'h9, 4'h4, 5'b00110);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_cnt", stall_cnt, 15);
        repeat (3) tick();
        chk("sat_hold", stall_cnt, 15);
        chk("sat_op1", out_op1, 64'hA5A5_A5A5_A5A5_A5A5);
        out_ready = 1'b1;
        tick();
        chk("sat_release", out_valid, 0);

`ifdef SKID_BUFFER_EN
        // Skid: two entries absorbed under back-pressure, released in order.
        out_ready = 1'b0;
        drive(1'b1, {4{16'h000A}}, {4{16'h00A0}}, 4'hA, 4'h1, 5'b10000);
        #1;
        chk("skid_rdy_a", in_ready, 1);
        tick();
        drive(1'b1, {4{16'h000B}}, {4{16'h00B0}}, 4'hB, 4'h2, 5'b01000);
        #1;
        chk("skid_rdy_b", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("skid_full_rdy", in_ready, 0);
        chk("skid_head_a", out_op1, 64'h000A_000A_000A_000A);
        out_ready = 1'b1;
        tick();
        chk("skid_second_valid", out_valid, 1);
        chk("skid_second_b", out_op1, 64'h000B_000B_000B_000B);
        tick();
        chk("skid_empty", out_valid, 0);

        out_ready = 1'b0;
        drive(1'b1, {4{16'h000C}}, {4{16'h00C0}}, 4'hC, 4'h3, 5'b10000);
        tick();
        drive(1'b1, {4{16'h000D}}, {4{16'h00D0}}, 4'hD, 4'h4, 5'b01000);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("skid_flush_valid", out_valid, 0);
        #1;
        chk("skid_flush_rdy", in_ready, 1);
        tick();
        chk("skid_flush_both_dropped", out_valid, 0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
